// File: rtl/an_code_pkg.sv
// Shared AN-code constants and encoder state type.
// Used by the encoder and by the remainder-based decoder blocks downstream.
package an_code_pkg;

    localparam int K  = 30;
    localparam int AW = 15;
    localparam int N  = K + AW;
    localparam int CW = $clog2(AW);

    // Bit AW-1 is set; (2^K-1)*A therefore fits in N bits without wrap.
    localparam logic [AW-1:0] A_CONST = AW'(18613);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } enc_state_t;

    function automatic logic a_bit(input logic [CW-1:0] idx);
        return A_CONST[idx];
    endfunction

endpackage

// File: rtl/an_shift_add_step.sv
// One shift-add iteration: adds md<<cnt to acc when the selected bit of A is set.
module an_shift_add_step
    import an_code_pkg::*;
(
    input  logic [N-1:0]  acc,
    input  logic [N-1:0]  md,
    input  logic [CW-1:0] cnt,
    input  logic          abit,
    output logic [N-1:0]  next_acc
);

    logic [N-1:0] shifted;

    // Shift result is truncated to N bits; sum wraps modulo 2^N.
    assign shifted  = md << cnt;
    assign next_acc = abit ? (acc + shifted) : acc;

endmodule

// File: rtl/an_encoder_seq.sv
// Sequential AN-code encoder: out_code = in_data * A, one bit of A per MUL cycle.
// Valid/ready on both sides; a new word is taken only after the previous result left.
module an_encoder_seq
    import an_code_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [K-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_code,
    output logic         busy
);

    localparam logic [CW-1:0] LAST_CNT = CW'(AW - 1);

    enc_state_t    state_reg, state_next;
    logic [N-1:0]  md_reg, md_next;
    logic [N-1:0]  acc_reg, acc_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [N-1:0]  code_reg, code_next;
    logic [N-1:0]  step_acc;

    an_shift_add_step u_step (
        .acc      (acc_reg),
        .md       (md_reg),
        .cnt      (cnt_reg),
        .abit     (a_bit(cnt_reg)),
        .next_acc (step_acc)
    );

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign out_code  = code_reg;

    always_comb begin
        state_next = state_reg;
        md_next    = md_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        code_next  = code_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    md_next    = N'(in_data);
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = MUL;
                end
            end
            MUL: begin
                acc_next = step_acc;
                cnt_next = cnt_reg + CW'(1);
                // Result register is separate so out_code survives the next accept.
                if (cnt_reg == LAST_CNT) begin
                    code_next  = step_acc;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            md_reg   <= '0;
            acc_reg  <= '0;
            cnt_reg  <= '0;
            code_reg <= '0;
        end else begin
            md_reg   <= md_next;
            acc_reg  <= acc_next;
            cnt_reg  <= cnt_next;
            code_reg <= code_next;
        end
    end

endmodule
